// File: rtl/bcd_line_formatter_pkg.sv
// Shared ASCII constants and FSM state encoding for the BCD line formatter.
package bcd_line_formatter_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    NEXT
  } state_e;

endpackage

// File: rtl/bcd_digit_to_ascii.sv
// Maps one BCD nibble to its ASCII character; a blanked digit becomes a space,
// and a non-decimal nibble becomes '?'.
module bcd_digit_to_ascii
  import bcd_line_formatter_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (blank_i) begin
      ascii_o = ASCII_SPACE;
    end else if (nibble_i > 4'd9) begin
      ascii_o = ASCII_QMARK;
    end else begin
      ascii_o = ASCII_ZERO + {4'h0, nibble_i};
    end
  end

endmodule

// File: rtl/bcd_line_formatter.sv
// Snapshots two BCD fields on start and streams them to the UART as one text
// line "AAAAAA BBBBBB\r\n", one byte per busy-flag handshake.
module bcd_line_formatter
  import bcd_line_formatter_pkg::*;
#(
  parameter int unsigned DIGITS              = 6,
  parameter logic [7:0]  SEPARATOR           = 8'h20,
  parameter bit          BLANK_LEADING_ZEROS = 1'b0,
  parameter int unsigned ACCEPT_TIMEOUT      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_a,
  input  logic [4*DIGITS-1:0]   bcd_b,
  output logic                  ready,
  output logic                  uart_wr,
  output logic [7:0]            uart_data,
  input  logic                  uart_busy,
  output logic [15:0]           lines_sent,
  output logic                  tx_timeout
);

  localparam int unsigned FIELD_W  = 4 * DIGITS;
  localparam int unsigned LINE_LEN = 2 * DIGITS + 3;
  localparam int unsigned IDX_W    = $clog2(LINE_LEN);
  localparam int unsigned TMO_W    = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACCEPT_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FIELD_W-1:0]   field_a_q, field_a_d;
  logic [FIELD_W-1:0]   field_b_q, field_b_d;
  logic [7:0]           data_q, data_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [15:0]          lines_q, lines_d;
  logic                 timeout_q, timeout_d;

  logic [3:0]           dig_a [DIGITS];
  logic [3:0]           dig_b [DIGITS];
  logic [DIGITS-1:0]    blank_a, blank_b;

  // A digit blanks when it and every higher digit of its field are zero; the
  // last digit of each field is never blanked so a zero field still shows "0".
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign dig_a[gi] = field_a_q[FIELD_W-1-4*gi -: 4];
    assign dig_b[gi] = field_b_q[FIELD_W-1-4*gi -: 4];
    if (BLANK_LEADING_ZEROS && (gi < DIGITS - 1)) begin : g_blank
      assign blank_a[gi] = (field_a_q[FIELD_W-1 -: 4*(gi+1)] == '0);
      assign blank_b[gi] = (field_b_q[FIELD_W-1 -: 4*(gi+1)] == '0);
    end else begin : g_keep
      assign blank_a[gi] = 1'b0;
      assign blank_b[gi] = 1'b0;
    end
  end

  logic [3:0] sel_nibble;
  logic       sel_blank;
  logic       sel_digit;
  logic [7:0] fixed_byte;
  logic [7:0] digit_byte;
  logic [7:0] load_byte;

  always_comb begin
    sel_nibble = '0;
    sel_blank  = 1'b0;
    sel_digit  = 1'b0;
    fixed_byte = ASCII_LF;
    if (idx_q == IDX_W'(DIGITS)) begin
      fixed_byte = SEPARATOR;
    end else if (idx_q == IDX_W'(2 * DIGITS + 1)) begin
      fixed_byte = ASCII_CR;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_digit  = 1'b1;
        sel_nibble = dig_a[i];
        sel_blank  = blank_a[i];
      end
      if (idx_q == IDX_W'(DIGITS + 1 + i)) begin
        sel_digit  = 1'b1;
        sel_nibble = dig_b[i];
        sel_blank  = blank_b[i];
      end
    end
  end

  bcd_digit_to_ascii u_digit (
    .nibble_i (sel_nibble),
    .blank_i  (sel_blank),
    .ascii_o  (digit_byte)
  );

  assign load_byte = sel_digit ? digit_byte : fixed_byte;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    field_a_d = field_a_q;
    field_b_d = field_b_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    lines_d   = lines_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          field_a_d = bcd_a;
          field_b_d = bcd_b;
          idx_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        data_d  = load_byte;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        // A UART that never acknowledges must not stall the line forever.
        if (uart_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          lines_d = lines_q + 16'd1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      field_a_q <= '0;
      field_b_q <= '0;
      data_q    <= 8'h00;
      tmo_q     <= '0;
      lines_q   <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      field_a_q <= field_a_d;
      field_b_q <= field_b_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      lines_q   <= lines_d;
      timeout_q <= timeout_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign uart_wr    = (state_q == ISSUE);
  assign uart_data  = data_q;
  assign lines_sent = lines_q;
  assign tx_timeout = timeout_q;

endmodule

// File: tb/tb_bcd_line_formatter.sv
// Directed bench: a plain and a zero-blanking formatter share stimulus, each
// with its own busy-flag UART model; captured lines are checked against text.
module tb_bcd_line_formatter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] bcd_a, bcd_b;

  logic        ready_p, wr_p, busy_p, to_p;
  logic [7:0]  data_p;
  logic [15:0] lines_p;
  logic        ready_b, wr_b, busy_b, to_b;
  logic [7:0]  data_b;
  logic [15:0] lines_b;

  always #5 clock = ~clock;

  bcd_line_formatter #(
    .DIGITS(6), .SEPARATOR(8'h20), .BLANK_LEADING_ZEROS(1'b0), .ACCEPT_TIMEOUT(4)
  ) u_plain (
    .clock(clock), .reset(reset), .start(start), .bcd_a(bcd_a), .bcd_b(bcd_b),
    .ready(ready_p), .uart_wr(wr_p), .uart_data(data_p), .uart_busy(busy_p),
    .lines_sent(lines_p), .tx_timeout(to_p)
  );

  bcd_line_formatter #(
    .DIGITS(6), .SEPARATOR(8'h20), .BLANK_LEADING_ZEROS(1'b1), .ACCEPT_TIMEOUT(4)
  ) u_blank (
    .clock(clock), .reset(reset), .start(start), .bcd_a(bcd_a), .bcd_b(bcd_b),
    .ready(ready_b), .uart_wr(wr_b), .uart_data(data_b), .uart_busy(busy_b),
    .lines_sent(lines_b), .tx_timeout(to_b)
  );

  // UART models: busy rises the cycle after a write and stays high 10 cycles.
  bit          never_busy = 1'b0;
  int unsigned bcnt_p = 0;
  int unsigned bcnt_b = 0;
  always @(posedge clock) begin
    if (never_busy)        bcnt_p <= 0;
    else if (wr_p)         bcnt_p <= 10;
    else if (bcnt_p != 0)  bcnt_p <= bcnt_p - 1;
    if (never_busy)        bcnt_b <= 0;
    else if (wr_b)         bcnt_b <= 10;
    else if (bcnt_b != 0)  bcnt_b <= bcnt_b - 1;
  end
  assign busy_p = (bcnt_p != 0);
  assign busy_b = (bcnt_b != 0);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [119:0] line_p = '0;
  logic [119:0] line_b = '0;
  int           n_p = 0;
  int           n_b = 0;
  int           wr_cyc  [256];
  logic         to_hist [256];
  always @(negedge clock) begin
    if (wr_p) begin
      line_p <= {line_p[111:0], data_p};
      if (n_p < 256) begin
        wr_cyc[n_p]  <= cyc;
        to_hist[n_p] <= to_p;
      end
      n_p <= n_p + 1;
    end
    if (wr_b) begin
      line_b <= {line_b[111:0], data_b};
      n_b <= n_b + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Issues one start, checks the two-edge latency to the first strobe, then
  // waits (bounded) for both formatters to return to ready.
  task automatic send_line(input logic [23:0] a, input logic [23:0] b, input bit mutate,
                           input bit spam, output int base_p, output int base_b);
    bit ok;
    base_p = n_p;
    base_b = n_b;
    @(negedge clock);
    bcd_a = a;
    bcd_b = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (mutate) bcd_a = 24'h999999;
    check("latency_load_no_wr", {127'd0, wr_p}, 128'd0);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (k == 0) check("latency_first_wr", {127'd0, wr_p}, 128'd1);
      if (ready_p && ready_b) begin
        ok = 1'b1;
        break;
      end
      start = spam && !ready_p && !ready_b && (k % 3 == 0);
    end
    start = 1'b0;
    check("line_done_in_time", {127'd0, ok}, 128'd1);
    $display("line a=%h b=%h plain=%h blank=%h lines=%0d timeout=%0d",
             a, b, line_p, line_b, lines_p, to_p);
  endtask

  typedef struct {
    logic [23:0]  a;
    logic [23:0]  b;
    bit           mutate;
    logic [119:0] exp_plain;
    logic [119:0] exp_blank;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int bp, bb, lines0, gmin, gmax, g;
    bit seen;

    reset = 1'b1;
    start = 1'b0;
    bcd_a = '0;
    bcd_b = '0;

    vecs[0].a = 24'h000817; vecs[0].b = 24'h001234; vecs[0].mutate = 1'b0;
    vecs[0].exp_plain = "000817 001234\r\n"; vecs[0].exp_blank = "   817   1234\r\n";
    vecs[1].a = 24'h000817; vecs[1].b = 24'h000000; vecs[1].mutate = 1'b0;
    vecs[1].exp_plain = "000817 000000\r\n"; vecs[1].exp_blank = "   817      0\r\n";
    vecs[2].a = 24'h00A001; vecs[2].b = 24'h000000; vecs[2].mutate = 1'b1;
    vecs[2].exp_plain = "00?001 000000\r\n"; vecs[2].exp_blank = "  ?001      0\r\n";
    vecs[3].a = 24'h123456; vecs[3].b = 24'h9F0000; vecs[3].mutate = 1'b0;
    vecs[3].exp_plain = "123456 9?0000\r\n"; vecs[3].exp_blank = "123456 9?0000\r\n";
    vecs[4].a = 24'h000000; vecs[4].b = 24'h100000; vecs[4].mutate = 1'b0;
    vecs[4].exp_plain = "000000 100000\r\n"; vecs[4].exp_blank = "     0 100000\r\n";

    repeat (3) @(negedge clock);
    check("rst_ready",  {127'd0, ready_p}, 128'd1);
    check("rst_wr",     {127'd0, wr_p},    128'd0);
    check("rst_data",   {120'd0, data_p},  128'd0);
    check("rst_lines",  {112'd0, lines_p}, 128'd0);
    check("rst_timeout",{127'd0, to_p},    128'd0);
    check("rst_ready_b",{127'd0, ready_b}, 128'd1);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      lines0 = int'(lines_p);
      send_line(vecs[v].a, vecs[v].b, vecs[v].mutate, 1'b0, bp, bb);
      check("plain_byte_count", 128'(n_p - bp), 128'd15);
      check("plain_line",       {8'd0, line_p}, {8'd0, vecs[v].exp_plain});
      check("blank_byte_count", 128'(n_b - bb), 128'd15);
      check("blank_line",       {8'd0, line_b}, {8'd0, vecs[v].exp_blank});
      check("plain_lines_sent", {112'd0, lines_p}, 128'(lines0 + 1));
      check("blank_lines_sent", {112'd0, lines_b}, 128'(lines0 + 1));
      check("no_timeout",       {127'd0, to_p},    128'd0);
      if (v == 0) begin
        gmin = 1000; gmax = 0;
        for (int i = bp + 1; i < bp + 15; i++) begin
          g = wr_cyc[i] - wr_cyc[i-1];
          if (g < gmin) gmin = g;
          if (g > gmax) gmax = g;
        end
        check("busy_gap_min", 128'(gmin), 128'd14);
        check("busy_gap_max", 128'(gmax), 128'd14);
      end
    end

    // Starts pulsed while busy must neither queue nor restart the line.
    lines0 = int'(lines_p);
    send_line(24'h000042, 24'h000007, 1'b0, 1'b1, bp, bb);
    repeat (40) @(negedge clock);
    check("spam_byte_count", 128'(n_p - bp), 128'd15);
    check("spam_line",       {8'd0, line_p}, {8'd0, 120'("000042 000007\r\n")});
    check("spam_lines_sent", {112'd0, lines_p}, 128'(lines0 + 1));
    check("spam_ready",      {127'd0, ready_p}, 128'd1);

    // Reset in the middle of a line.
    bp = n_p;
    @(negedge clock);
    bcd_a = 24'h000817; bcd_b = 24'h001234; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (n_p - bp >= 5) begin
        seen = 1'b1;
        break;
      end
    end
    check("midline_five_wr", {127'd0, seen}, 128'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_wr",    {127'd0, wr_p},    128'd0);
    check("midrst_data",  {120'd0, data_p},  128'd0);
    check("midrst_ready", {127'd0, ready_p}, 128'd1);
    check("midrst_lines", {112'd0, lines_p}, 128'd0);
    repeat (12) @(negedge clock);
    reset = 1'b0;
    send_line(24'h000817, 24'h001234, 1'b0, 1'b0, bp, bb);
    check("after_rst_count", 128'(n_p - bp), 128'd15);
    check("after_rst_line",  {8'd0, line_p}, {8'd0, 120'("000817 001234\r\n")});
    check("after_rst_lines", {112'd0, lines_p}, 128'd1);

    // UART never acknowledges: every byte times out but the line completes.
    never_busy = 1'b1;
    repeat (3) @(negedge clock);
    send_line(24'h000817, 24'h001234, 1'b0, 1'b0, bp, bb);
    check("tmo_byte_count",   128'(n_p - bp), 128'd15);
    check("tmo_line",         {8'd0, line_p}, {8'd0, 120'("000817 001234\r\n")});
    check("tmo_lines",        {112'd0, lines_p}, 128'd2);
    check("tmo_clear_first",  {127'd0, to_hist[bp]},   128'd0);
    check("tmo_set_second",   {127'd0, to_hist[bp+1]}, 128'd1);
    check("tmo_sticky",       {127'd0, to_p}, 128'd1);
    gmin = 1000; gmax = 0;
    for (int i = bp + 1; i < bp + 15; i++) begin
      g = wr_cyc[i] - wr_cyc[i-1];
      if (g < gmin) gmin = g;
      if (g > gmax) gmax = g;
    end
    check("tmo_gap_min", 128'(gmin), 128'd7);
    check("tmo_gap_max", 128'(gmax), 128'd7);
    never_busy = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("tmo_cleared_by_reset", {127'd0, to_p}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
